// File: rtl/gpio_debounce_pkg.sv
// gpio_debounce_pkg: default parameters and width helper shared by the debouncer files
package gpio_debounce_pkg;
  localparam int DW_DEF       = 16;
  localparam int PRESCALE_DEF = 1000;
  localparam int SAMPLES_DEF  = 4;
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/gpio_debounce_db_bit.sv
// db_bit: one-pin synchroniser, tick-based debouncer and edge pulse generator
// ports: clk, rst (sync active-low), tick_i (enabled sample tick), en_i, pin_i (async pin),
//        stable_o (debounced level), rise_o/fall_o (one-cycle pulses), edge_o (accept this cycle, unregistered)
module db_bit
  import gpio_debounce_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic en_i,
  input  logic pin_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_o
);
  localparam int CW = cw(SAMPLES + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, rise_q, fall_q;
  logic          differ, accept;
  assign differ = sync_q[1] ^ stable_q;
  assign accept = tick_i && differ && cnt_q == CW'(SAMPLES - 1);
  // any agreeing tick or an accept restarts the count; off-tick cycles hold it
  always_comb cnt_d = (!en_i || (tick_i && (!differ || accept))) ? '0 : tick_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], pin_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_q ^ accept;
      rise_q   <= accept & sync_q[1];
      fall_q   <= accept & ~sync_q[1];
    end
  end
  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign edge_o   = accept;
endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce: synchronises and debounces DW GPIO input pins against a shared sample tick
// ports: clk, rst (sync active-low), en (debounce enable), pin_in (raw pins),
//        gpio_db (debounced level), rise/fall (one-cycle edge pulses), any_edge (OR of pulses)
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int SAMPLES  = SAMPLES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] pin_in,
  output logic [DW-1:0] gpio_db,
  output logic [DW-1:0] rise,
  output logic [DW-1:0] fall,
  output logic          any_edge
);
  localparam int PW = cw(PRESCALE);
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0] acc;
  logic          tick, any_edge_q;
  assign tick = en && pcnt_q == PW'(PRESCALE - 1);
  // disabling parks the prescaler at 0 so re-enable starts a full period
  always_comb pcnt_d = (!en || tick) ? '0 : pcnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_q     <= '0;
      any_edge_q <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      any_edge_q <= |acc;
    end
  end
  assign any_edge = any_edge_q;
  for (genvar i = 0; i < DW; i++) begin : g_bit
    db_bit #(.SAMPLES(SAMPLES)) u_bit (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (tick),
      .en_i    (en),
      .pin_i   (pin_in[i]),
      .stable_o(gpio_db[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i]),
      .edge_o  (acc[i])
    );
  end
endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: directed and random checks of gpio_debounce against a behavioural model
module tb_gpio_debounce;
  localparam int DW = 16, P = 4, S = 3;
  logic          clk = 1'b0, rst = 1'b0, en = 1'b1;
  logic [DW-1:0] pin_in = '1;
  logic [DW-1:0] gpio_db, rise, fall;
  logic          any_edge;
  int            tests = 0, fails = 0;
  logic [DW-1:0] hist[$];
  int            en_cyc, run[DW];
  logic [DW-1:0] m_db, m_rise, m_fall;
  logic          m_any;
  int            lat, n5, n12, n6;

  always #5 clk = ~clk;

  gpio_debounce #(.DW(DW), .PRESCALE(P), .SAMPLES(S)) dut (
    .clk(clk), .rst(rst), .en(en), .pin_in(pin_in),
    .gpio_db(gpio_db), .rise(rise), .fall(fall), .any_edge(any_edge)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
    tests++;
    assert (got >= lo && got <= hi) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic model_reset();
    hist = {16'h0, 16'h0};
    en_cyc = 0;
    foreach (run[b]) run[b] = 0;
    m_db = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
  endtask

  // pins reach the debouncer two edges late; ticks fall on every P-th enabled edge
  task automatic model_edge();
    logic [DW-1:0] sync;
    logic          tk;
    if (!rst) begin
      model_reset();
      return;
    end
    sync = hist[0];
    void'(hist.pop_front());
    hist.push_back(pin_in);
    tk = en && (en_cyc % P == P - 1);
    en_cyc = en ? en_cyc + 1 : 0;
    m_rise = '0; m_fall = '0;
    for (int b = 0; b < DW; b++) begin
      if (!en) run[b] = 0;
      else if (tk) begin
        if (sync[b] != m_db[b]) begin
          run[b]++;
          if (run[b] == S) begin
            run[b] = 0;
            m_db[b] = sync[b];
            if (sync[b]) m_rise[b] = 1'b1; else m_fall[b] = 1'b1;
          end
        end else run[b] = 0;
      end
    end
    m_any = |(m_rise | m_fall);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gpio_db", gpio_db, m_db);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("any_edge", {15'b0, any_edge}, {15'b0, m_any});
  endtask

  task automatic run_until_rise(input logic [DW-1:0] mask, input int lim, output int l);
    l = -1;
    for (int n = 1; n <= lim && l < 0; n++) begin
      step();
      if ((rise & mask) != '0) l = n;
    end
  endtask

  task automatic run_until_cnt(input int b, input int lim);
    int k = 0;
    while (run[b] != 2 && k < lim) begin
      step();
      k++;
    end
    chk_rng("cnt_reach", run[b], 2, 2);
  endtask

  initial begin
    model_reset();
    repeat (5) begin
      step();
      chk("rst_db", gpio_db, 16'h0);
    end
    rst = 1'b1;
    run_until_rise(16'hFFFF, 20, lat);
    chk_rng("rst_rise_lat", lat, 11, 15);
    chk("rst_rise", rise, 16'hFFFF);
    step();
    chk("rst_db_after", gpio_db, 16'hFFFF);

    pin_in = '0;
    repeat (20) step();
    pin_in = 16'h0001;
    run_until_rise(16'h0001, 20, lat);
    chk_rng("step_lat", lat, 11, 15);
    chk("step_rise", rise, 16'h0001);
    chk("step_any", {15'b0, any_edge}, 16'h0001);
    chk("step_fall", fall, 16'h0);

    pin_in[3] = 1'b1;
    repeat (6) step();
    pin_in[3] = 1'b0;
    n5 = 0;
    repeat (20) begin
      step();
      n5 += int'(rise[3] | fall[3]);
    end
    chk("glitch_db", {15'b0, gpio_db[3]}, 16'h0);
    chk_rng("glitch_pulses", n5, 0, 0);

    pin_in = 16'h0027;
    repeat (20) step();
    pin_in[2:1] = 2'b00;
    n5 = 0; n12 = 0; n6 = 0;
    for (int k = 0; k < 8; k++) begin
      pin_in[5] = k[0];
      step();
      n5 += int'(fall[5]);
      n12 += int'(fall[1] | fall[2]);
      n6 += int'(fall[2:1] == 2'b11);
    end
    pin_in[5] = 1'b0;
    repeat (20) begin
      step();
      n5 += int'(fall[5]);
      n12 += int'(fall[1] | fall[2]);
      n6 += int'(fall[2:1] == 2'b11);
    end
    chk_rng("simul_fall12", n6, 1, 1);
    chk_rng("simul_fall12_cycles", n12, 1, 1);
    chk_rng("bounce_fall5", n5, 1, 1);
    chk("simul_db", gpio_db, 16'h0001);

    pin_in[7] = 1'b1;
    run_until_cnt(7, 20);
    en = 1'b0;
    repeat (3) step();
    chk("en_hold", {15'b0, gpio_db[7]}, 16'h0);
    en = 1'b1;
    run_until_rise(16'h0080, 20, lat);
    chk_rng("en_restart_lat", lat, 12, 12);

    pin_in[8] = 1'b1;
    run_until_cnt(8, 20);
    rst = 1'b0;
    step();
    chk("midrst_db", gpio_db, 16'h0);
    rst = 1'b1;

    repeat (400) begin
      if ($urandom % 10 == 0) pin_in ^= 16'($urandom) & 16'($urandom);
      en  = ($urandom % 40) != 0;
      rst = ($urandom % 150) != 0;
      step();
    end
    en = 1'b1; rst = 1'b1;
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
